// File: rtl/led_scan_receiver.sv
// led_scan_receiver: receive end of the LED-matrix row-scan interface.
// Rebuilds per-row red/green strobes into whole frames, publishes each frame
// atomically once its last row arrives, and flags scan-sequence faults.
module led_scan_receiver #(
  parameter int ROWS            = 16,
  parameter int COLS            = 16,
  parameter int COLS_ACTIVE_LOW = 0,
  parameter int TIMEOUT         = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       row_valid,
  input  logic [3:0]                 row_addr,
  input  logic [COLS-1:0]            red_cols,
  input  logic [COLS-1:0]            grn_cols,
  output logic [ROWS-1:0][COLS-1:0]  frame_red,
  output logic [ROWS-1:0][COLS-1:0]  frame_grn,
  output logic                       frame_valid,
  output logic [15:0]                frame_count,
  output logic                       seq_error,
  output logic                       locked
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [3:0]    LAST_ROW  = 4'(ROWS - 1);
  localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t                     state_q, state_d;
  logic [3:0]                 exp_q, exp_d;
  logic [TW-1:0]              tcnt_q, tcnt_d;
  logic [ROWS-1:0][COLS-1:0]  sh_red_q, sh_red_d;
  logic [ROWS-1:0][COLS-1:0]  sh_grn_q, sh_grn_d;
  logic [ROWS-1:0][COLS-1:0]  frame_red_q, frame_red_d;
  logic [ROWS-1:0][COLS-1:0]  frame_grn_q, frame_grn_d;
  logic                       frame_valid_q, frame_valid_d;
  logic [15:0]                frame_count_q, frame_count_d;
  logic                       seq_error_q, seq_error_d;
  logic                       locked_q, locked_d;

  logic [COLS-1:0]            cap_red, cap_grn;
  logic [3:0]                 prev_row;

  // Column words as captured: inverted when the driver sinks current.
  always_comb begin
    cap_red  = (COLS_ACTIVE_LOW != 0) ? ~red_cols : red_cols;
    cap_grn  = (COLS_ACTIVE_LOW != 0) ? ~grn_cols : grn_cols;
    prev_row = exp_q - 4'd1;
  end

  // Next-state logic: row sequencing, shadow capture, publish and fault detection.
  always_comb begin
    state_d       = state_q;
    exp_d         = exp_q;
    tcnt_d        = tcnt_q;
    sh_red_d      = sh_red_q;
    sh_grn_d      = sh_grn_q;
    frame_red_d   = frame_red_q;
    frame_grn_d   = frame_grn_q;
    frame_valid_d = 1'b0;
    frame_count_d = frame_count_q;
    seq_error_d   = 1'b0;

    case (state_q)
      HUNT: begin
        tcnt_d = '0;
        if (row_valid && row_addr == 4'd0) begin
          sh_red_d[0] = cap_red;
          sh_grn_d[0] = cap_grn;
          exp_d       = 4'd1;
          state_d     = COLLECT;
        end
      end

      COLLECT: begin
        if (row_valid) begin
          tcnt_d = '0;
          if (row_addr == exp_q) begin
            sh_red_d[row_addr] = cap_red;
            sh_grn_d[row_addr] = cap_grn;
            if (row_addr == LAST_ROW) begin
              // Publish from the updated shadow so the last row lands in the same edge.
              frame_red_d   = sh_red_d;
              frame_grn_d   = sh_grn_d;
              frame_valid_d = 1'b1;
              frame_count_d = frame_count_q + 16'd1;
              exp_d         = 4'd0;
            end else begin
              exp_d = exp_q + 4'd1;
            end
          end else if (row_addr == prev_row) begin
            sh_red_d[row_addr] = cap_red;
            sh_grn_d[row_addr] = cap_grn;
          end else if (row_addr == 4'd0) begin
            seq_error_d = 1'b1;
            sh_red_d    = '0;
            sh_grn_d    = '0;
            sh_red_d[0] = cap_red;
            sh_grn_d[0] = cap_grn;
            exp_d       = 4'd1;
          end else begin
            seq_error_d = 1'b1;
            sh_red_d    = '0;
            sh_grn_d    = '0;
            exp_d       = 4'd0;
            state_d     = HUNT;
          end
        end else if (tcnt_q == TOUT_LAST) begin
          seq_error_d = 1'b1;
          sh_red_d    = '0;
          sh_grn_d    = '0;
          exp_d       = 4'd0;
          tcnt_d      = '0;
          state_d     = HUNT;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end

      default: begin
        state_d = HUNT;
        exp_d   = 4'd0;
        tcnt_d  = '0;
      end
    endcase

    locked_d = (state_d == COLLECT);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= HUNT;
      exp_q         <= 4'd0;
      tcnt_q        <= '0;
      sh_red_q      <= '0;
      sh_grn_q      <= '0;
      frame_red_q   <= '0;
      frame_grn_q   <= '0;
      frame_valid_q <= 1'b0;
      frame_count_q <= '0;
      seq_error_q   <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      exp_q         <= exp_d;
      tcnt_q        <= tcnt_d;
      sh_red_q      <= sh_red_d;
      sh_grn_q      <= sh_grn_d;
      frame_red_q   <= frame_red_d;
      frame_grn_q   <= frame_grn_d;
      frame_valid_q <= frame_valid_d;
      frame_count_q <= frame_count_d;
      seq_error_q   <= seq_error_d;
      locked_q      <= locked_d;
    end
  end

  assign frame_red   = frame_red_q;
  assign frame_grn   = frame_grn_q;
  assign frame_valid = frame_valid_q;
  assign frame_count = frame_count_q;
  assign seq_error   = seq_error_q;
  assign locked      = locked_q;

endmodule
